// File: rtl/vga_write_arbiter.sv
// Shares one registered VGA pixel-write port among NUM_REQ drawing engines: PRIO_REQ always wins, the rest rotate.
// req -> grant in 1 cycle, granted write -> VGA_write 1 cycle later; bursts are capped at MAX_BURST, ungranted writes are dropped and counted.
module vga_write_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter int          nX          = 10,
   parameter int          nY          = 9,
   parameter int          COLOR_DEPTH = 9,
   parameter int          PRIO_REQ    = 0,
   parameter logic [15:0] MAX_BURST   = 16'd3600
) (
   input  logic                           Clock,
   input  logic                           Resetn,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*nX-1:0]          req_x,
   input  logic [NUM_REQ*nY-1:0]          req_y,
   input  logic [NUM_REQ*COLOR_DEPTH-1:0] req_color,
   input  logic [NUM_REQ-1:0]             req_write,
   output logic [NUM_REQ-1:0]             grant,
   output logic [nX-1:0]                  VGA_x,
   output logic [nY-1:0]                  VGA_y,
   output logic [COLOR_DEPTH-1:0]         VGA_color,
   output logic                           VGA_write,
   output logic                           busy,
   output logic [15:0]                    drop_count
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t                   state_q, state_d;
   logic [NUM_REQ-1:0]       grant_q, grant_d;
   logic [IW-1:0]            last_id_q, last_id_d;
   logic [15:0]              burst_cnt_q, burst_cnt_d;
   logic [15:0]              drop_cnt_q, drop_cnt_d;
   logic                     cut_vld_q, cut_vld_d;
   logic [IW-1:0]            cut_id_q, cut_id_d;
   logic [nX-1:0]            vga_x_q, vga_x_d;
   logic [nY-1:0]            vga_y_q, vga_y_d;
   logic [COLOR_DEPTH-1:0]   vga_color_q, vga_color_d;
   logic                     vga_write_q, vga_write_d;

   logic [nX-1:0]            sel_x;
   logic [nY-1:0]            sel_y;
   logic [COLOR_DEPTH-1:0]   sel_color;
   logic                     sel_req, sel_write;

   logic [NUM_REQ-1:0]       cut_mask, others, elig;
   logic [IW-1:0]            rr_idx, rr_id, win_id;
   logic                     rr_found;

   // last_id_q doubles as the id of the current owner while in S_GRANT
   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      sel_req   = 1'b0;
      sel_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == last_id_q) begin
            sel_x     = req_x[i*nX +: nX];
            sel_y     = req_y[i*nY +: nY];
            sel_color = req_color[i*COLOR_DEPTH +: COLOR_DEPTH];
            sel_req   = req[i];
            sel_write = req_write[i];
         end
      end
   end

   // A timed-out engine only loses its turn when somebody else is actually waiting
   always_comb begin
      cut_mask = cut_vld_q ? (NUM_REQ'(1) << cut_id_q) : '0;
      others   = req & ~cut_mask;
      elig     = (others != '0) ? others : req;
      rr_idx   = '0;
      rr_id    = '0;
      rr_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = IW'((int'(last_id_q) + k) % NUM_REQ);
         if (!rr_found && elig[rr_idx]) begin
            rr_found = 1'b1;
            rr_id    = rr_idx;
         end
      end
      win_id = elig[PRIO_REQ] ? IW'(PRIO_REQ) : rr_id;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_id_d   = last_id_q;
      burst_cnt_d = burst_cnt_q;
      cut_vld_d   = cut_vld_q;
      cut_id_d    = cut_id_q;
      vga_x_d     = vga_x_q;
      vga_y_d     = vga_y_q;
      vga_color_d = vga_color_q;
      vga_write_d = 1'b0;
      drop_cnt_d  = drop_cnt_q;

      if (((req_write & ~grant_q) != '0) && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;

      unique case (state_q)
         S_IDLE: begin
            if (req != '0) begin
               grant_d     = NUM_REQ'(1) << win_id;
               last_id_d   = win_id;
               burst_cnt_d = '0;
               cut_vld_d   = 1'b0;
               state_d     = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!sel_req) begin
               grant_d = '0;
               state_d = S_GAP;
            end else begin
               vga_x_d     = sel_x;
               vga_y_d     = sel_y;
               vga_color_d = sel_color;
               vga_write_d = sel_write;
               if (sel_write) begin
                  burst_cnt_d = burst_cnt_q + 16'd1;
                  if (burst_cnt_q + 16'd1 == MAX_BURST) begin
                     grant_d   = '0;
                     state_d   = S_GAP;
                     cut_vld_d = 1'b1;
                     cut_id_d  = last_id_q;
                  end
               end
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         last_id_q   <= IW'(NUM_REQ - 1);
         burst_cnt_q <= '0;
         drop_cnt_q  <= '0;
         cut_vld_q   <= 1'b0;
         cut_id_q    <= '0;
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         vga_color_q <= '0;
         vga_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_id_q   <= last_id_d;
         burst_cnt_q <= burst_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         cut_vld_q   <= cut_vld_d;
         cut_id_q    <= cut_id_d;
         vga_x_q     <= vga_x_d;
         vga_y_q     <= vga_y_d;
         vga_color_q <= vga_color_d;
         vga_write_q <= vga_write_d;
      end
   end

   assign grant      = grant_q;
   assign VGA_x      = vga_x_q;
   assign VGA_y      = vga_y_q;
   assign VGA_color  = vga_color_q;
   assign VGA_write  = vga_write_q;
   assign busy       = (state_q == S_GRANT);
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a transaction-level arbiter model.
module tb_vga_write_arbiter;
   localparam int          NR   = 4;
   localparam int          NX   = 10;
   localparam int          NY   = 9;
   localparam int          CD   = 9;
   localparam int          PRIO = 0;
   localparam logic [15:0] MAXB = 16'd4;

   logic              Clock = 1'b0;
   logic              Resetn = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR-1:0]     req_write = '0;
   logic [NR*NX-1:0]  req_x = '0;
   logic [NR*NY-1:0]  req_y = '0;
   logic [NR*CD-1:0]  req_color = '0;
   logic [NR-1:0]     grant;
   logic [NX-1:0]     VGA_x;
   logic [NY-1:0]     VGA_y;
   logic [CD-1:0]     VGA_color;
   logic              VGA_write;
   logic              busy;
   logic [15:0]       drop_count;

   int total = 0;
   int bad = 0;

   always #5 Clock = ~Clock;

   vga_write_arbiter #(
      .NUM_REQ(NR), .nX(NX), .nY(NY), .COLOR_DEPTH(CD), .PRIO_REQ(PRIO), .MAX_BURST(MAXB)
   ) dut (
      .Clock(Clock), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .req_write(req_write), .grant(grant), .VGA_x(VGA_x),
      .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write), .busy(busy),
      .drop_count(drop_count)
   );

   // model: phase 0 = free, 1 = owned, 2 = one-cycle gap
   int          m_ph, m_owner, m_last, m_cnt, m_cut_id;
   bit          m_cut_v;
   logic [NR-1:0] e_grant;
   logic [NX-1:0] e_x;
   logic [NY-1:0] e_y;
   logic [CD-1:0] e_c;
   logic          e_wr;
   logic [15:0]   e_drop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // candidate order: priority engine first, then rotation after the last winner
   function automatic int pick();
      int  order[$];
      bit  skip_cut;
      order.push_back(PRIO);
      for (int k = 1; k <= NR; k++)
         if ((m_last + k) % NR != PRIO) order.push_back((m_last + k) % NR);
      skip_cut = 1'b0;
      if (m_cut_v)
         for (int i = 0; i < NR; i++)
            if (i != m_cut_id && req[i]) skip_cut = 1'b1;
      foreach (order[i])
         if (req[order[i]] && !(skip_cut && order[i] == m_cut_id)) return order[i];
      return 0;
   endfunction

   task automatic model_update();
      int w;
      if (!Resetn) begin
         m_ph = 0; m_owner = 0; m_last = NR - 1; m_cnt = 0; m_cut_v = 1'b0; m_cut_id = 0;
         e_grant = '0; e_x = '0; e_y = '0; e_c = '0; e_wr = 1'b0; e_drop = '0;
         return;
      end
      if ((req_write & ~e_grant) != '0 && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
      e_wr = 1'b0;
      case (m_ph)
         0: if (req != '0) begin
               w = pick();
               m_owner = w; m_last = w; m_cnt = 0; m_cut_v = 1'b0;
               e_grant = NR'(1) << w;
               m_ph = 1;
            end
         1: if (!req[m_owner]) begin
               e_grant = '0; m_ph = 2;
            end else begin
               e_x  = req_x[m_owner*NX +: NX];
               e_y  = req_y[m_owner*NY +: NY];
               e_c  = req_color[m_owner*CD +: CD];
               e_wr = req_write[m_owner];
               if (e_wr) m_cnt++;
               if (m_cnt == int'(MAXB)) begin
                  e_grant = '0; m_ph = 2; m_cut_v = 1'b1; m_cut_id = m_owner;
               end
            end
         default: m_ph = 0;
      endcase
   endtask

   task automatic cycle();
      @(posedge Clock);
      model_update();
      #1;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("vga_write", 32'(VGA_write), 32'(e_wr));
      chk("vga_x", 32'(VGA_x), 32'(e_x));
      chk("vga_y", 32'(VGA_y), 32'(e_y));
      chk("vga_color", 32'(VGA_color), 32'(e_c));
      chk("busy", 32'(busy), 32'(m_ph == 1));
      chk("drop_count", 32'(drop_count), 32'(e_drop));
   endtask

   initial begin
      // reset state
      Resetn = 1'b0;
      cycle(); cycle();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_drop", 32'(drop_count), 32'h0);
      Resetn = 1'b1;

      // single burst, pass-through latency
      req = 4'b0001;
      cycle();
      chk("t1_grant", 32'(grant), 32'h1);
      for (int i = 0; i < 3; i++) begin
         req_write = 4'b0001;
         req_x[0 +: NX] = NX'(10 + i);
         cycle();
         chk("t1_wr", 32'(VGA_write), 32'h1);
         chk("t1_x", 32'(VGA_x), 32'(10 + i));
      end
      req = '0; req_write = '0;
      cycle(); cycle();

      // round robin from last_id=3 after reset
      Resetn = 1'b0; cycle(); Resetn = 1'b1;
      req = 4'b0110;
      cycle();
      chk("t2_first", 32'(grant), 32'h2);
      req = 4'b0100;
      cycle(); cycle(); cycle();
      chk("t2_second", 32'(grant), 32'h4);

      // no preemption by the priority engine
      req = '0; cycle(); cycle();
      req = 4'b0010; cycle();
      req = 4'b0011; cycle(); cycle();
      chk("t3_hold", 32'(grant), 32'h2);
      req = 4'b0001;
      cycle();
      chk("t3_r1", 32'(grant), 32'h0);
      cycle(); cycle();
      chk("t3_r3", 32'(grant), 32'h1);

      // ungranted writes only bump the drop counter
      req_write = 4'b1000;
      for (int i = 0; i < 5; i++) cycle();
      chk("t5_drop", 32'(drop_count), 32'd5);
      chk("t5_vga", 32'(VGA_write), 32'h0);
      req_write = '0;

      // burst cap releases the owner and hands over to the waiting engine
      req = '0; cycle(); cycle();
      req = 4'b1100; cycle();
      chk("t4_grant", 32'(grant), 32'h4);
      req_write = 4'b0100;
      for (int i = 0; i < 4; i++) cycle();
      chk("t4_cap", 32'(grant), 32'h0);
      chk("t4_last_wr", 32'(VGA_write), 32'h1);
      req_write = '0;
      cycle(); cycle();
      chk("t4_next", 32'(grant), 32'h8);

      // reset mid-burst
      req = 4'b0100; cycle(); cycle(); cycle();
      chk("t6_own", 32'(grant), 32'h4);
      req_write = 4'b0101; cycle(); cycle();
      Resetn = 1'b0; req = 4'b1100; req_write = '0;
      cycle();
      chk("t6_grant", 32'(grant), 32'h0);
      chk("t6_wr", 32'(VGA_write), 32'h0);
      chk("t6_drop", 32'(drop_count), 32'h0);
      Resetn = 1'b1;
      cycle();
      chk("t6_rr", 32'(grant), 32'h4);
      req = '0; cycle(); cycle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         Resetn = ($urandom_range(499) != 0);
         for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
               if ($urandom_range(7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               req[i] = 1'b1;
            end
            req_x[i*NX +: NX]     = NX'($urandom);
            req_y[i*NY +: NY]     = NY'($urandom);
            req_color[i*CD +: CD] = CD'($urandom);
         end
         req_write = NR'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
